// File: rtl/trail_stack.sv
// Assignment trail for the DPLL core: a stack of (variable, value, type) entries
// with decision-level tracking and a hardware backtrack that unwinds to the last decision.
module trail_stack #(
  parameter int DEPTH = 128,
  parameter int VAR_W = 9,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             backtrack,
  input  logic             t_type,
  input  logic             val,
  input  logic [VAR_W-1:0] variable,
  output logic             busy,
  output logic             out_valid,
  output logic             last,
  output logic             type_out,
  output logic             val_out,
  output logic [VAR_W-1:0] variable_out,
  output logic             empty,
  output logic             full,
  output logic             done,
  output logic             unsat,
  output logic             overflow,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] level
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = VAR_W + 2;

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_BACKTRACK = 1'b1;

  // Entry layout: {type, value, variable}; type 0 = decision, 1 = forced.
  logic [ENT_W-1:0] mem [DEPTH];

  logic [0:0]       state;
  logic             idle;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [ENT_W-1:0] top_ent;
  logic [ENT_W-1:0] new_ent;
  logic             top_is_d;
  logic             new_is_d;
  logic             cmd_ok;
  logic             bt_empty;
  logic             bt_start;
  logic             bt_pop;
  logic             bt_end;
  logic             do_replace;
  logic             do_push;
  logic             do_ovf;
  logic             do_pop;
  logic             emit;
  logic             wr_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign busy  = (state == ST_BACKTRACK);

  always_comb begin
    idle     = (state == ST_IDLE);
    top_idx  = empty ? '0 : IDX_W'(count - CNT_W'(1));
    top_ent  = mem[top_idx];
    top_is_d = ~top_ent[ENT_W-1];
    new_ent  = {t_type, val, variable};
    new_is_d = ~t_type;

    // backtrack outranks push/pop; everything is ignored while busy
    bt_empty   = idle && backtrack && empty;
    bt_start   = idle && backtrack && !empty;
    cmd_ok     = idle && !backtrack;
    do_replace = cmd_ok && push && pop && !empty;
    do_push    = cmd_ok && push && !do_replace && !full;
    do_ovf     = cmd_ok && push && !do_replace && full;
    do_pop     = cmd_ok && pop && !push && !empty;

    // The stack is never empty while in BACKTRACK: the sequence ends on the last entry
    bt_pop = !idle;
    bt_end = bt_pop && (top_is_d || (count == CNT_W'(1)));

    emit   = do_replace || do_pop || bt_pop;
    wr_en  = do_replace || do_push;
    wr_idx = do_replace ? top_idx : IDX_W'(count);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= new_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      level        <= '0;
      out_valid    <= 1'b0;
      last         <= 1'b0;
      done         <= 1'b0;
      type_out     <= 1'b0;
      val_out      <= 1'b0;
      variable_out <= '0;
      unsat        <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      out_valid <= emit;
      last      <= bt_end;
      done      <= bt_end || bt_empty;

      if (emit) begin
        {type_out, val_out, variable_out} <= top_ent;
      end

      if (bt_empty) begin
        unsat <= 1'b1;
      end
      if (do_ovf) begin
        overflow <= 1'b1;
      end

      if (bt_start) begin
        state <= ST_BACKTRACK;
      end
      if (bt_end) begin
        state <= ST_IDLE;
        // Ending on a forced entry means the trail drained with no decision left
        if (!top_is_d) begin
          unsat <= 1'b1;
        end
      end

      if (do_push) begin
        count <= count + CNT_W'(1);
      end else if (do_pop || bt_pop) begin
        count <= count - CNT_W'(1);
      end

      if (do_push) begin
        level <= level + CNT_W'(new_is_d);
      end else if (do_replace) begin
        level <= level - CNT_W'(top_is_d) + CNT_W'(new_is_d);
      end else if (do_pop || bt_pop) begin
        level <= level - CNT_W'(top_is_d);
      end
    end
  end

endmodule

// File: tb/tb_trail_stack.sv
// Bench for trail_stack: directed vector table, hand-written reset-during-backtrack
// sequence, then randomized traffic against a queue-based trail model.
module tb_trail_stack;

  localparam int DEPTH = 8;
  localparam int VAR_W = 9;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             backtrack = 1'b0;
  logic             t_type = 1'b0;
  logic             val = 1'b0;
  logic [VAR_W-1:0] variable = '0;
  logic             busy, out_valid, last, type_out, val_out;
  logic [VAR_W-1:0] variable_out;
  logic             empty, full, done, unsat, overflow;
  logic [CNT_W-1:0] count, level;

  trail_stack #(.DEPTH(DEPTH), .VAR_W(VAR_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .backtrack(backtrack),
    .t_type(t_type), .val(val), .variable(variable),
    .busy(busy), .out_valid(out_valid), .last(last), .type_out(type_out),
    .val_out(val_out), .variable_out(variable_out), .empty(empty), .full(full),
    .done(done), .unsat(unsat), .overflow(overflow), .count(count), .level(level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int p, po, b, t, v, n;
    int e_ov, e_last, e_done, e_busy, e_t, e_n, e_cnt, e_lvl, e_unsat, e_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int p, po, b, t, v, n,
                     input int ov, la, dn, bs, et, en, c, l, u, o);
    vec_t r;
    r = '{p, po, b, t, v, n, ov, la, dn, bs, et, en, c, l, u, o};
    tbl.push_back(r);
  endtask

  task automatic drive(input int p, po, b, t, v, n);
    push      = p[0];
    pop       = po[0];
    backtrack = b[0];
    t_type    = t[0];
    val       = v[0];
    variable  = VAR_W'(n);
  endtask

  task automatic apply(input vec_t r, input int idx);
    drive(r.p, r.po, r.b, r.t, r.v, r.n);
    @(posedge clk);
    #1;
    chk($sformatf("row%0d out_valid", idx), out_valid, r.e_ov);
    if (r.e_ov != 0) begin
      chk($sformatf("row%0d last", idx), last, r.e_last);
      chk($sformatf("row%0d type_out", idx), type_out, r.e_t);
      chk($sformatf("row%0d variable_out", idx), variable_out, r.e_n);
    end
    chk($sformatf("row%0d done", idx), done, r.e_done);
    chk($sformatf("row%0d busy", idx), busy, r.e_busy);
    chk($sformatf("row%0d count", idx), count, r.e_cnt);
    chk($sformatf("row%0d level", idx), level, r.e_lvl);
    chk($sformatf("row%0d empty", idx), empty, int'(r.e_cnt == 0));
    chk($sformatf("row%0d full", idx), full, int'(r.e_cnt == DEPTH));
    chk($sformatf("row%0d unsat", idx), unsat, r.e_unsat);
    chk($sformatf("row%0d overflow", idx), overflow, r.e_ovf);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model: the trail is a queue (back = top); a backtrack moves the
  // entries it will stream into a pending queue, emitted one per cycle.
  typedef struct packed {
    logic             t;
    logic             v;
    logic [VAR_W-1:0] n;
  } ent_t;

  ent_t mq[$];
  ent_t pend[$];
  ent_t m_out;
  bit   m_unsat, m_ovf, pend_unsat;

  task automatic model_clear();
    mq.delete();
    pend.delete();
    m_out      = '0;
    m_unsat    = 1'b0;
    m_ovf      = 1'b0;
    pend_unsat = 1'b0;
  endtask

  function automatic int model_level();
    int l = 0;
    foreach (mq[i]) if (!mq[i].t) l++;
    foreach (pend[i]) if (!pend[i].t) l++;
    return l;
  endfunction

  task automatic model_step(input bit p, input bit po, input bit b, input ent_t ne,
                            output bit e_ov, output bit e_last, output bit e_done);
    e_ov = 1'b0; e_last = 1'b0; e_done = 1'b0;
    if (pend.size() > 0) begin
      m_out = pend.pop_front();
      e_ov  = 1'b1;
      if (pend.size() == 0) begin
        e_last = 1'b1;
        e_done = 1'b1;
        if (pend_unsat) m_unsat = 1'b1;
      end
    end else if (b) begin
      if (mq.size() == 0) begin
        e_done  = 1'b1;
        m_unsat = 1'b1;
      end else begin
        ent_t e;
        do begin
          e = mq.pop_back();
          pend.push_back(e);
        end while (e.t && mq.size() > 0);
        pend_unsat = e.t;
      end
    end else if (p && po && mq.size() > 0) begin
      m_out = mq.pop_back();
      e_ov  = 1'b1;
      mq.push_back(ne);
    end else if (p) begin
      if (mq.size() == DEPTH) m_ovf = 1'b1;
      else mq.push_back(ne);
    end else if (po && mq.size() > 0) begin
      m_out = mq.pop_back();
      e_ov  = 1'b1;
    end
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("reset count", count, 0);
    chk("reset level", level, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset last", last, 0);
    chk("reset done", done, 0);
    chk("reset unsat", unsat, 0);
    chk("reset overflow", overflow, 0);

    // ---------------- directed vector table ----------------
    //   p po b  t v  n     ov la dn bs et en   cnt lvl u o
    add(1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    add(1, 0, 0, 1, 0, 7,   0, 0, 0, 0, 0, 0,   2, 1, 0, 0);
    add(1, 0, 0, 1, 1, 9,   0, 0, 0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0,   3, 1, 0, 0);
    add(1, 0, 0, 0, 1, 99,  1, 0, 0, 1, 1, 9,   2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 1, 7,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 3,   0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0,   1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 2,   0, 0, 0, 0, 0, 0,   2, 2, 0, 0);
    add(1, 0, 0, 1, 1, 5,   0, 0, 0, 0, 0, 0,   3, 2, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0,   3, 2, 0, 0);
    add(0, 0, 1, 0, 0, 0,   1, 0, 0, 1, 1, 5,   2, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 2,   1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1,   0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 4,   0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 6,   0, 0, 0, 0, 0, 0,   2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0,   2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 6,   1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 1, 4,   0, 0, 1, 0);
    add(1, 0, 0, 0, 1, 2,   0, 0, 0, 0, 0, 0,   1, 1, 1, 0);
    add(1, 1, 0, 1, 0, 8,   1, 0, 0, 0, 0, 2,   1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 8,   0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0,   0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      add(1, 0, 0, i % 2, 1, 20 + i,  0, 0, 0, 0, 0, 0,  i + 1, i / 2 + 1, 1, 0);
    end
    add(1, 0, 0, 0, 1, 50,  0, 0, 0, 0, 0, 0,   8, 4, 1, 1);
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 27,  7, 4, 1, 1);

    foreach (tbl[i]) apply(tbl[i], i);

    // ---------------- reset during a 5-entry backtrack ----------------
    do_reset();
    apply('{1, 0, 0, 0, 1, 30,  0, 0, 0, 0, 0, 0,  1, 1, 0, 0}, 100);
    for (int i = 1; i < 5; i++) begin
      apply('{1, 0, 0, 1, 0, 30 + i,  0, 0, 0, 0, 0, 0,  i + 1, 1, 0, 0}, 100 + i);
    end
    apply('{0, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0,   5, 1, 0, 0}, 105);
    apply('{1, 1, 1, 0, 1, 77,  1, 0, 0, 1, 1, 34,  4, 1, 0, 0}, 106);
    #2;
    reset = 1'b1;
    drive(1, 0, 0, 0, 0, 5);
    @(posedge clk);
    #1;
    chk("rst-bt busy", busy, 0);
    chk("rst-bt count", count, 0);
    chk("rst-bt level", level, 0);
    chk("rst-bt empty", empty, 1);
    chk("rst-bt out_valid", out_valid, 0);
    chk("rst-bt done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst-bt after done", done, 0);
    chk("rst-bt after out_valid", out_valid, 0);
    chk("rst-bt after busy", busy, 0);
    chk("rst-bt after count", count, 0);

    // ---------------- randomized traffic vs. model ----------------
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      int   r;
      bit   p, po, b, eov, ela, edn;
      ent_t ne;
      r  = int'($urandom_range(0, 99));
      p  = 1'b0; po = 1'b0; b = 1'b0;
      if (r < 5) b = 1'b1;
      else if (r < 55) p = 1'b1;
      else if (r < 80) po = 1'b1;
      else if (r < 90) begin p = 1'b1; po = 1'b1; end
      ne.t = ($urandom_range(0, 2) != 0);
      ne.v = 1'($urandom_range(0, 1));
      ne.n = VAR_W'($urandom_range(0, (1 << VAR_W) - 1));
      drive(int'(p), int'(po), int'(b), int'(ne.t), int'(ne.v), int'(ne.n));
      model_step(p, po, b, ne, eov, ela, edn);
      @(posedge clk);
      #1;
      chk("rnd out_valid", out_valid, int'(eov));
      if (eov) chk("rnd last", last, int'(ela));
      chk("rnd done", done, int'(edn));
      chk("rnd busy", busy, int'(pend.size() > 0));
      chk("rnd type_out", type_out, int'(m_out.t));
      chk("rnd val_out", val_out, int'(m_out.v));
      chk("rnd variable_out", variable_out, int'(m_out.n));
      chk("rnd count", count, mq.size() + pend.size());
      chk("rnd level", level, model_level());
      chk("rnd empty", empty, int'(mq.size() + pend.size() == 0));
      chk("rnd full", full, int'(mq.size() + pend.size() == DEPTH));
      chk("rnd unsat", unsat, int'(m_unsat));
      chk("rnd overflow", overflow, int'(m_ovf));
      // occasional reset keeps the sticky flags from saturating the run
      if (i % 700 == 699) begin
        do_reset();
        model_clear();
      end
    end

    drive(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
